// File: rtl/multicycle_control_unit_pkg.sv
// Shared definitions for the multicycle MIPS controller.
// Holds the opcode/funct constants, FSM state encodings, ALU_op codes,
// datapath select constants and the DECODE dispatch helper.
package multicycle_control_unit_pkg;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct codes understood by the ALU decoder
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // FSM state encodings (12 used, 4 spare codes recover to FETCH)
  localparam int STATE_BITS = 4;
  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECUTE  = 4'd6;
  localparam logic [3:0] S_ALUWB    = 4'd7;
  localparam logic [3:0] S_BRANCH   = 4'd8;
  localparam logic [3:0] S_ADDIEX   = 4'd9;
  localparam logic [3:0] S_ADDIWB   = 4'd10;
  localparam logic [3:0] S_JUMP     = 4'd11;

  // Internal ALU operation class handed to the ALU decoder
  typedef enum logic [1:0] {
    ALU_OP_ADD   = 2'b00,
    ALU_OP_SUB   = 2'b01,
    ALU_OP_FUNCT = 2'b10
  } alu_op_e;

  // ALU_control encodings
  localparam logic [2:0] ALU_CTL_ADD = 3'b010;
  localparam logic [2:0] ALU_CTL_SUB = 3'b110;
  localparam logic [2:0] ALU_CTL_AND = 3'b000;
  localparam logic [2:0] ALU_CTL_OR  = 3'b001;
  localparam logic [2:0] ALU_CTL_SLT = 3'b111;

  // pc_src selects
  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  // ALU_srcB selects
  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // State that follows DECODE for a given opcode. S_FETCH means the
  // opcode is unsupported (or compiled out) and must be flagged illegal.
  function automatic logic [3:0] decode_target(input logic [5:0] op,
                                               input logic addi_en,
                                               input logic j_en);
    logic [3:0] tgt;
    tgt = S_FETCH;
    case (op)
      OP_RTYPE:     tgt = S_EXECUTE;
      OP_LW, OP_SW: tgt = S_MEMADR;
      OP_BEQ:       tgt = S_BRANCH;
      OP_ADDI:      tgt = addi_en ? S_ADDIEX : S_FETCH;
      OP_J:         tgt = j_en ? S_JUMP : S_FETCH;
      default:      tgt = S_FETCH;
    endcase
    return tgt;
  endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Controller <-> datapath bundle for the multicycle MIPS controller.
// master: the controller (consumes IR fields/flags, drives the selects).
// slave : the datapath side (drives IR fields/flags, consumes the selects).
// Signals:
//   op, funct       IR opcode / funct fields
//   zero, mem_ready ALU zero flag, memory access complete
//   iord .. instr_done  datapath controls and status strobes
//   state           current FSM state (debug, STATE_W bits)
interface multicycle_control_unit_if #(
  parameter int STATE_W = 4
);
  logic [5:0]         op;
  logic [5:0]         funct;
  logic               zero;
  logic               mem_ready;
  logic               iord;
  logic               mem_write;
  logic               ir_write;
  logic               pc_en;
  logic [1:0]         pc_src;
  logic               ALU_srcA;
  logic [1:0]         ALU_srcB;
  logic [2:0]         ALU_control;
  logic               reg_write;
  logic               reg_dst;
  logic               mem_to_reg;
  logic               illegal_op;
  logic               instr_done;
  logic [STATE_W-1:0] state;

  modport master (
    input  op, funct, zero, mem_ready,
    output iord, mem_write, ir_write, pc_en, pc_src, ALU_srcA, ALU_srcB,
           ALU_control, reg_write, reg_dst, mem_to_reg, illegal_op,
           instr_done, state
  );

  modport slave (
    output op, funct, zero, mem_ready,
    input  iord, mem_write, ir_write, pc_en, pc_src, ALU_srcA, ALU_srcB,
           ALU_control, reg_write, reg_dst, mem_to_reg, illegal_op,
           instr_done, state
  );
endinterface

// File: rtl/multicycle_control_unit_alu_decoder.sv
// ALU decoder shared with the single-cycle core.
// Ports:
//   alu_op      in  2  00 add, 01 sub, 10 decode funct
//   funct       in  6  R-type funct field
//   alu_control out 3  ALU operation select
// Unrecognised funct codes fall back to add so the ALU never sees an
// undefined select.
module multicycle_control_unit_alu_decoder
  import multicycle_control_unit_pkg::*;
(
  input  alu_op_e    alu_op,
  input  logic [5:0] funct,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_CTL_ADD;
    case (alu_op)
      ALU_OP_ADD: alu_control = ALU_CTL_ADD;
      ALU_OP_SUB: alu_control = ALU_CTL_SUB;
      default: begin
        case (funct)
          FN_ADD:  alu_control = ALU_CTL_ADD;
          FN_SUB:  alu_control = ALU_CTL_SUB;
          FN_AND:  alu_control = ALU_CTL_AND;
          FN_OR:   alu_control = ALU_CTL_OR;
          FN_SLT:  alu_control = ALU_CTL_SLT;
          default: alu_control = ALU_CTL_ADD;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS controller: Moore FSM sequencing each instruction over
// 3-5 cycles (plus memory wait cycles) and driving the datapath selects.
// Ports:
//   clk    in  rising-edge clock
//   reset  in  asynchronous active-high; returns the FSM to FETCH
//   bus    master side of multicycle_control_unit_if (IR fields, zero,
//          mem_ready in; iord/mem_write/ir_write/pc_en/pc_src/ALU_srcA/
//          ALU_srcB/ALU_control/reg_write/reg_dst/mem_to_reg/illegal_op/
//          instr_done/state out)
// Parameters:
//   MEM_HANDSHAKE  1: FETCH/MEMREAD/MEMWRITE wait for mem_ready
//   SUPPORT_ADDI   0: addi is flagged illegal
//   SUPPORT_JUMP   0: j is flagged illegal
//   STATE_W        width of the debug state output (>= 4)
module multicycle_control_unit
  import multicycle_control_unit_pkg::*;
#(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter bit SUPPORT_ADDI  = 1'b1,
  parameter bit SUPPORT_JUMP  = 1'b1,
  parameter int STATE_W       = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  multicycle_control_unit_if.master     bus
);

  logic [STATE_BITS-1:0] state_reg;
  logic [STATE_BITS-1:0] state_next;
  logic [STATE_BITS-1:0] decode_next;
  logic                  rdy;
  logic                  pc_write;
  logic                  branch;
  alu_op_e               alu_op;
  logic [STATE_W-1:0]    state_ext;

  // Without the handshake, memory is assumed to answer in one cycle.
  assign rdy = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;

  assign decode_next = decode_target(bus.op, SUPPORT_ADDI, SUPPORT_JUMP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= S_FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and Moore outputs; only rdy and zero gate the outputs.
  always_comb begin
    state_next     = S_FETCH;
    bus.iord       = 1'b0;
    bus.mem_write  = 1'b0;
    bus.ir_write   = 1'b0;
    bus.pc_src     = PC_SRC_ALU;
    bus.ALU_srcA   = 1'b0;
    bus.ALU_srcB   = SRCB_B;
    bus.reg_write  = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.illegal_op = 1'b0;
    bus.instr_done = 1'b0;
    pc_write       = 1'b0;
    branch         = 1'b0;
    alu_op         = ALU_OP_ADD;

    case (state_reg)
      S_FETCH: begin
        bus.ALU_srcB = SRCB_FOUR;
        bus.pc_src   = PC_SRC_ALU;
        bus.ir_write = rdy;
        pc_write     = rdy;
        state_next   = rdy ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // Branch target is precomputed here while the register file reads.
        bus.ALU_srcB = SRCB_IMM_SH;
        state_next   = decode_next;
        if (decode_next == S_FETCH) begin
          bus.illegal_op = 1'b1;
          bus.instr_done = 1'b1;
        end
      end
      S_MEMADR: begin
        bus.ALU_srcA = 1'b1;
        bus.ALU_srcB = SRCB_IMM;
        state_next   = (bus.op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        bus.iord   = 1'b1;
        state_next = rdy ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        bus.mem_to_reg = 1'b1;
        bus.reg_write  = 1'b1;
        bus.instr_done = 1'b1;
        state_next     = S_FETCH;
      end
      S_MEMWRITE: begin
        // Write strobe is held until the memory accepts it.
        bus.iord       = 1'b1;
        bus.mem_write  = 1'b1;
        bus.instr_done = rdy;
        state_next     = rdy ? S_FETCH : S_MEMWRITE;
      end
      S_EXECUTE: begin
        bus.ALU_srcA = 1'b1;
        bus.ALU_srcB = SRCB_B;
        alu_op       = ALU_OP_FUNCT;
        state_next   = S_ALUWB;
      end
      S_ALUWB: begin
        bus.reg_dst    = 1'b1;
        bus.reg_write  = 1'b1;
        bus.instr_done = 1'b1;
        state_next     = S_FETCH;
      end
      S_BRANCH: begin
        bus.ALU_srcA   = 1'b1;
        bus.ALU_srcB   = SRCB_B;
        alu_op         = ALU_OP_SUB;
        bus.pc_src     = PC_SRC_ALUOUT;
        branch         = 1'b1;
        bus.instr_done = 1'b1;
        state_next     = S_FETCH;
      end
      S_ADDIEX: begin
        bus.ALU_srcA = 1'b1;
        bus.ALU_srcB = SRCB_IMM;
        state_next   = S_ADDIWB;
      end
      S_ADDIWB: begin
        bus.reg_write  = 1'b1;
        bus.instr_done = 1'b1;
        state_next     = S_FETCH;
      end
      S_JUMP: begin
        bus.pc_src     = PC_SRC_JUMP;
        pc_write       = 1'b1;
        bus.instr_done = 1'b1;
        state_next     = S_FETCH;
      end
      default: begin
        // Spare encodings: all enables low, recover to FETCH.
        state_next = S_FETCH;
      end
    endcase

    bus.pc_en = pc_write | (branch & bus.zero);
  end

  always_comb begin
    state_ext = '0;
    state_ext[STATE_BITS-1:0] = state_reg;
  end
  assign bus.state = state_ext;

  multicycle_control_unit_alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct       (bus.funct),
    .alu_control (bus.ALU_control)
  );

endmodule

// File: tb/tb_multicycle_control_unit.sv
module tb_multicycle_control_unit;
  import multicycle_control_unit_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // dut0: all features on; dut1: no handshake, no addi, no j
  multicycle_control_unit_if #(.STATE_W(4)) bus0 ();
  multicycle_control_unit_if #(.STATE_W(4)) bus1 ();

  multicycle_control_unit #(
    .MEM_HANDSHAKE(1'b1), .SUPPORT_ADDI(1'b1), .SUPPORT_JUMP(1'b1), .STATE_W(4)
  ) dut0 (.clk(clk), .reset(reset), .bus(bus0));

  multicycle_control_unit #(
    .MEM_HANDSHAKE(1'b0), .SUPPORT_ADDI(1'b0), .SUPPORT_JUMP(1'b0), .STATE_W(4)
  ) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  logic [5:0]  op_v[2];
  logic [5:0]  funct_v[2];
  logic        zero_v[2];
  logic        mr_v[2];
  logic [16:0] act_v[2];

  assign bus0.op = op_v[0];  assign bus0.funct = funct_v[0];
  assign bus0.zero = zero_v[0];  assign bus0.mem_ready = mr_v[0];
  assign bus1.op = op_v[1];  assign bus1.funct = funct_v[1];
  assign bus1.zero = zero_v[1];  assign bus1.mem_ready = mr_v[1];

  assign act_v[0] = {bus0.iord, bus0.mem_write, bus0.ir_write, bus0.pc_en, bus0.pc_src,
                     bus0.ALU_srcA, bus0.ALU_srcB, bus0.ALU_control, bus0.reg_write,
                     bus0.reg_dst, bus0.mem_to_reg, bus0.illegal_op, bus0.instr_done};
  assign act_v[1] = {bus1.iord, bus1.mem_write, bus1.ir_write, bus1.pc_en, bus1.pc_src,
                     bus1.ALU_srcA, bus1.ALU_srcB, bus1.ALU_control, bus1.reg_write,
                     bus1.reg_dst, bus1.mem_to_reg, bus1.illegal_op, bus1.instr_done};

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum int {P_FETCH, P_DECODE, P_MEMADR, P_MEMREAD, P_MEMWB, P_MEMWRITE,
                    P_EXEC, P_ALUWB, P_BRANCH, P_ADDIEX, P_ADDIWB, P_JUMP} step_t;
  typedef enum int {C_R, C_LW, C_SW, C_BEQ, C_ADDI, C_J, C_ILL} cls_t;

  function automatic cls_t classify(input logic [5:0] op, input int d);
    case (op)
      6'h00:   return C_R;
      6'h23:   return C_LW;
      6'h2b:   return C_SW;
      6'h04:   return C_BEQ;
      6'h08:   return (d == 0) ? C_ADDI : C_ILL;
      6'h02:   return (d == 0) ? C_J : C_ILL;
      default: return C_ILL;
    endcase
  endfunction

  // Steps after DECODE for each instruction class
  function automatic int body_len(input cls_t c);
    case (c)
      C_R: return 2;  C_LW: return 3;  C_SW: return 2;  C_BEQ: return 1;
      C_ADDI: return 2;  C_J: return 1;  default: return 0;
    endcase
  endfunction

  function automatic step_t body(input cls_t c, input int k);
    case (c)
      C_R:    return (k == 0) ? P_EXEC : P_ALUWB;
      C_LW:   return (k == 0) ? P_MEMADR : (k == 1) ? P_MEMREAD : P_MEMWB;
      C_SW:   return (k == 0) ? P_MEMADR : P_MEMWRITE;
      C_BEQ:  return P_BRANCH;
      C_ADDI: return (k == 0) ? P_ADDIEX : P_ADDIWB;
      C_J:    return P_JUMP;
      default: return P_FETCH;
    endcase
  endfunction

  // Cycle counts with memory always ready
  function automatic int base_lat(input cls_t c);
    case (c)
      C_R: return 4;  C_LW: return 5;  C_SW: return 4;  C_BEQ: return 3;
      C_ADDI: return 4;  C_J: return 3;  default: return 2;
    endcase
  endfunction

  function automatic logic [2:0] funct_alu(input logic [5:0] f);
    case (f)
      6'h20: return 3'b010;  6'h22: return 3'b110;  6'h24: return 3'b000;
      6'h25: return 3'b001;  6'h2a: return 3'b111;  default: return 3'b010;
    endcase
  endfunction

  function automatic logic [16:0] expect_out(input step_t s, input logic r, input logic z,
                                            input logic [5:0] op, input logic [5:0] f,
                                            input int d);
    logic iord, mw, irw, pcen, srca, rw, rdst, m2r, ill, done;
    logic [1:0] pcsrc, srcb;
    logic [2:0] alu;
    {iord, mw, irw, pcen, srca, rw, rdst, m2r, ill, done} = '0;
    pcsrc = 2'b00; srcb = 2'b00; alu = 3'b010;
    case (s)
      P_FETCH:    begin srcb = 2'b01; irw = r; pcen = r; end
      P_DECODE:   begin srcb = 2'b11; ill = (classify(op, d) == C_ILL); done = ill; end
      P_MEMADR:   begin srca = 1'b1; srcb = 2'b10; end
      P_MEMREAD:  iord = 1'b1;
      P_MEMWB:    begin m2r = 1'b1; rw = 1'b1; done = 1'b1; end
      P_MEMWRITE: begin iord = 1'b1; mw = 1'b1; done = r; end
      P_EXEC:     begin srca = 1'b1; alu = funct_alu(f); end
      P_ALUWB:    begin rdst = 1'b1; rw = 1'b1; done = 1'b1; end
      P_BRANCH:   begin srca = 1'b1; alu = 3'b110; pcsrc = 2'b01; pcen = z; done = 1'b1; end
      P_ADDIEX:   begin srca = 1'b1; srcb = 2'b10; end
      P_ADDIWB:   begin rw = 1'b1; done = 1'b1; end
      P_JUMP:     begin pcsrc = 2'b10; pcen = 1'b1; done = 1'b1; end
      default:    ;
    endcase
    return {iord, mw, irw, pcen, pcsrc, srca, srcb, alu, rw, rdst, m2r, ill, done};
  endfunction

  // phase 0 = fetch, 1 = decode, 2+ = body step (phase-2)
  int   phase[2]   = '{0, 0};
  int   phase_n[2] = '{0, 0};
  cls_t cls_r[2]   = '{C_R, C_R};
  cls_t cls_n[2]   = '{C_R, C_R};
  int   lat[2]     = '{0, 0};
  int   lat_n[2]   = '{0, 0};
  int   stl[2]     = '{0, 0};
  int   stl_n[2]   = '{0, 0};

  function automatic step_t cur_step(input int d);
    if (phase[d] == 0) return P_FETCH;
    if (phase[d] == 1) return P_DECODE;
    return body(cls_r[d], phase[d] - 2);
  endfunction

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin : per_dut
      step_t s;
      logic r, stall;
      cls_t c;
      logic [16:0] e;
      int cnt, st;
      s = cur_step(d);
      r = (d == 0) ? mr_v[d] : 1'b1;
      e = expect_out(s, r, zero_v[d], op_v[d], funct_v[d], d);
      checks++;
      if (act_v[d] !== e) begin
        errors++;
        $display("FAIL model dut%0d step %s got %05h expected %05h at %0t",
                 d, s.name(), act_v[d], e, $time);
      end
      c = (phase[d] == 1) ? classify(op_v[d], d) : cls_r[d];
      stall = ((s == P_FETCH) || (s == P_MEMREAD) || (s == P_MEMWRITE)) && !r;
      cnt = lat[d] + 1;
      st  = stl[d] + (stall ? 1 : 0);
      if (act_v[d][0] && !reset) begin
        chk($sformatf("latency dut%0d %s", d, c.name()), cnt, base_lat(c) + st);
        lat_n[d] = 0; stl_n[d] = 0;
      end else begin
        lat_n[d] = cnt; stl_n[d] = st;
      end
      cls_n[d] = cls_r[d];
      if (phase[d] == 0) begin
        phase_n[d] = r ? 1 : 0;
      end else if (phase[d] == 1) begin
        cls_n[d] = c;
        phase_n[d] = (body_len(c) == 0) ? 0 : 2;
      end else if (stall) begin
        phase_n[d] = phase[d];
      end else begin
        phase_n[d] = (phase[d] - 1 < body_len(cls_r[d])) ? phase[d] + 1 : 0;
      end
    end
  end

  always @(posedge clk or posedge reset) begin
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        phase[d] <= 0; lat[d] <= 0; stl[d] <= 0;
      end else begin
        phase[d] <= phase_n[d]; cls_r[d] <= cls_n[d];
        lat[d] <= lat_n[d]; stl[d] <= stl_n[d];
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] pick_op();
    case ($urandom_range(0, 7))
      0: return 6'h00;  1: return 6'h23;  2: return 6'h2b;  3: return 6'h04;
      4: return 6'h08;  5: return 6'h02;  6: return 6'($urandom_range(0, 63));
      default: return 6'h3f;
    endcase
  endfunction

  function automatic logic [5:0] pick_funct();
    case ($urandom_range(0, 4))
      0: return 6'h20;  1: return 6'h22;  2: return 6'h24;  3: return 6'h25;
      default: return 6'h2a;
    endcase
  endfunction

  initial begin
    for (int d = 0; d < 2; d++) begin
      op_v[d] = 6'h00; funct_v[d] = 6'h20; zero_v[d] = 1'b0; mr_v[d] = 1'b0;
    end
    op_v[1] = 6'h3f;
    reset = 1'b1;

    // Reset state with memory not ready
    @(negedge clk);
    chk("rst_state", int'(bus0.state), int'(S_FETCH));
    chk("rst_ir_write", int'(bus0.ir_write), 0);
    chk("rst_pc_en", int'(bus0.pc_en), 0);
    chk("rst_mem_write", int'(bus0.mem_write), 0);
    chk("rst_reg_write", int'(bus0.reg_write), 0);
    chk("rst_srcB", int'(bus0.ALU_srcB), 1);
    edge_step();
    reset = 1'b0;
    mr_v[0] = 1'b1;

    // R-type add
    op_v[0] = 6'h00; funct_v[0] = 6'h20;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c < 4) chk("r_done_early", int'(bus0.instr_done), 0);
      if (c == 3) begin
        chk("r_alu_ctl", int'(bus0.ALU_control), 2);
        chk("r_srcB", int'(bus0.ALU_srcB), 0);
      end
      if (c == 4) begin
        chk("r_reg_dst", int'(bus0.reg_dst), 1);
        chk("r_reg_write", int'(bus0.reg_write), 1);
        chk("r_done", int'(bus0.instr_done), 1);
      end
      edge_step();
    end

    // lw: 2 wait cycles in FETCH, 1 in MEMREAD -> MEMWB at cycle 8
    op_v[0] = 6'h23;
    for (int c = 1; c <= 8; c++) begin
      mr_v[0] = (c <= 2 || c == 6) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (c <= 2) begin
        chk("lw_wait_pc_en", int'(bus0.pc_en), 0);
        chk("lw_wait_ir_write", int'(bus0.ir_write), 0);
      end
      if (c == 6) chk("lw_memread_iord", int'(bus0.iord), 1);
      if (c == 8) begin
        chk("lw_mem_to_reg", int'(bus0.mem_to_reg), 1);
        chk("lw_reg_write", int'(bus0.reg_write), 1);
      end
      edge_step();
    end

    // sw: 3 wait cycles in MEMWRITE
    op_v[0] = 6'h2b;
    for (int c = 1; c <= 7; c++) begin
      mr_v[0] = (c >= 4 && c <= 6) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (c >= 4) begin
        chk("sw_mem_write", int'(bus0.mem_write), 1);
        chk("sw_iord", int'(bus0.iord), 1);
        chk("sw_done", int'(bus0.instr_done), (c == 7) ? 1 : 0);
      end
      edge_step();
    end
    mr_v[0] = 1'b1;

    // beq taken then not taken
    for (int z = 1; z >= 0; z--) begin
      op_v[0] = 6'h04; zero_v[0] = z[0];
      for (int c = 1; c <= 3; c++) begin
        @(negedge clk);
        if (c == 3) begin
          chk("beq_alu_ctl", int'(bus0.ALU_control), 6);
          chk("beq_pc_src", int'(bus0.pc_src), 1);
          chk($sformatf("beq_pc_en_z%0d", z), int'(bus0.pc_en), z);
        end
        edge_step();
      end
    end
    zero_v[0] = 1'b0;

    // Illegal opcode on dut0, j on dut1 (jump disabled)
    reset = 1'b1; op_v[0] = 6'h3f; op_v[1] = 6'h02;
    edge_step();
    reset = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      if (c == 2) begin
        chk("ill_flag_d0", int'(bus0.illegal_op), 1);
        chk("ill_done_d0", int'(bus0.instr_done), 1);
        chk("ill_we_d0", int'({bus0.mem_write, bus0.reg_write, bus0.ir_write, bus0.pc_en}), 0);
        chk("ill_flag_d1", int'(bus1.illegal_op), 1);
        chk("ill_done_d1", int'(bus1.instr_done), 1);
        chk("ill_we_d1", int'({bus1.mem_write, bus1.reg_write, bus1.ir_write, bus1.pc_en}), 0);
      end
      edge_step();
    end

    // Reset in the middle of a stalled MEMREAD
    op_v[0] = 6'h23;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk("ill_back_fetch_d0", int'(bus0.state), int'(S_FETCH));
        chk("ill_back_fetch_d1", int'(bus1.state), int'(S_FETCH));
      end
      edge_step();
    end
    mr_v[0] = 1'b0;
    @(negedge clk);
    chk("mid_memread_iord", int'(bus0.iord), 1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_state", int'(bus0.state), int'(S_FETCH));
    chk("mid_rst_iord", int'(bus0.iord), 0);
    chk("mid_rst_mem_write", int'(bus0.mem_write), 0);
    chk("mid_rst_reg_write", int'(bus0.reg_write), 0);
    chk("mid_rst_ir_write", int'(bus0.ir_write), 0);
    edge_step();
    reset = 1'b0;

    // Randomised traffic checked against the model every cycle
    repeat (4000) begin
      reset = ($urandom_range(0, 299) == 0);
      for (int d = 0; d < 2; d++) begin
        if (phase[d] == 0) begin
          op_v[d] = pick_op();
          funct_v[d] = pick_funct();
        end
        mr_v[d] = ($urandom_range(0, 3) != 0);
        zero_v[d] = 1'($urandom_range(0, 1));
      end
      edge_step();
    end
    reset = 1'b0;
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
Multicycle MIPS controller. A Moore FSM sequences each instruction over 3-5 cycles and drives the shared-memory, IR, PC and ALU datapath selects. It adds a memory-ready handshake, illegal-opcode flagging and an instruction-done strobe, none of which the single-cycle decoder provides. The ALU_control decode reuses the existing ALU_decoder.

Parameters:
MEM_HANDSHAKE, 1, 1: memory states wait for mem_ready; 0: mem_ready ignored and treated as 1
SUPPORT_ADDI, 1, 1: addi decoded; 0: addi treated as illegal
SUPPORT_JUMP, 1, 1: j decoded; 0: j treated as illegal
STATE_W, 4, width of state debug output (at least 4)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high; forces state to FETCH
op  in  6  opcode from instruction register
funct  in  6  funct field from instruction register
zero  in  1  ALU zero flag
mem_ready  in  1  memory access completes this cycle
iord  out  1  0: memory address = PC; 1: memory address = ALUOut
mem_write  out  1  memory write enable
ir_write  out  1  IR load enable
pc_en  out  1  PC load enable = pc_write | (branch & zero)
pc_src  out  2  00: ALU result; 01: ALUOut; 10: jump target
ALU_srcA  out  1  0: PC; 1: A register
ALU_srcB  out  2  00: B; 01: constant 4; 10: SignImm; 11: SignImm<<2
ALU_control  out  3  ALU operation, from ALU_decoder
reg_write  out  1  register file write enable
reg_dst  out  1  0: rt; 1: rd
mem_to_reg  out  1  0: ALUOut; 1: Data register
illegal_op  out  1  one-cycle pulse in DECODE when op is unsupported
instr_done  out  1  pulse in the final cycle of each instruction
state  out  STATE_W  current state encoding (debug)

Behaviour:
- Opcodes: R 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
- State register is the only storage. All outputs are combinational from state; exceptions are gating by rdy (mem_ready, or 1 when MEM_HANDSHAKE=0) and by zero.
- Any output not listed for a state is 0. ALU_op is internal: 00 add, 01 sub, 10 use funct.
- FETCH: srcB=01, op00, pc_src=00. ir_write=rdy, pc_write=rdy. -> DECODE on rdy, else stay.
- DECODE: srcB=11, op00. Next state by opcode:
  - R -> EXECUTE
  - lw/sw -> MEMADR
  - beq -> BRANCH
  - addi -> ADDIEX
  - j -> JUMP
  - unsupported or disabled -> FETCH, with illegal_op=1 and instr_done=1
- MEMADR: srcA=1, srcB=10, op00. -> MEMREAD if lw, MEMWRITE if sw.
- MEMREAD: iord=1. -> MEMWB on rdy.
- MEMWB: mem_to_reg=1, reg_write=1, instr_done=1. -> FETCH.
- MEMWRITE: iord=1, mem_write=1, held until rdy. instr_done=rdy. -> FETCH on rdy.
- EXECUTE: srcA=1, srcB=00, op10. -> ALUWB.
- ALUWB: reg_dst=1, reg_write=1, instr_done=1. -> FETCH.
- BRANCH: srcA=1, srcB=00, op01, pc_src=01, branch=1, instr_done=1. -> FETCH.
- ADDIEX: srcA=1, srcB=10, op00. -> ADDIWB.
- ADDIWB: reg_write=1, instr_done=1. -> FETCH.
- JUMP: pc_src=10, pc_write=1, instr_done=1. -> FETCH.
- Reset (any cycle, including mid-instruction or mid-wait): state=FETCH immediately. Outputs then show FETCH values; with rdy=0 that is srcB=01 and every enable 0. No write enable is asserted in the reset cycle except gated FETCH ir_write/pc_write after deassertion.
- Latency with rdy always 1: R 4, lw 5, sw 4, beq 3, j 3, addi 4, illegal 2 cycles. Each rdy-low cycle in FETCH/MEMREAD/MEMWRITE adds one cycle.
- ALU_control: ALU_decoder mapping. op00 -> 010, op01 -> 110. op10 by funct: add 100000 -> 010, sub 100010 -> 110, and 100100 -> 000, or 100101 -> 001, slt 101010 -> 111.
- Unreachable state encodings -> FETCH next cycle with all enables 0.

Decomposition:
- Shared package: opcode constants, state encodings, ALU_op codes, pc_src/ALU_srcB select constants.
- Sub-module: existing ALU_decoder, instantiated unchanged. FSM next-state and output logic stay in this module.

Test Plan:
- Reset asserted mid-MEMREAD -> state=FETCH same cycle; iord=0, mem_write=0, reg_write=0.
- R-type add (op 000000, funct 100000), rdy=1 -> FETCH, DECODE, EXECUTE (ALU_control=010, srcB=00), ALUWB (reg_dst=1, reg_write=1, instr_done=1); 4 cycles.
- lw with mem_ready low 2 cycles in FETCH and 1 cycle in MEMREAD -> pc_en/ir_write 0 while waiting; MEMWB reached at cycle 8; mem_to_reg=1.
- sw with mem_ready low 3 cycles in MEMWRITE -> mem_write held 1 for 4 cycles with iord=1; instr_done only on the rdy cycle.
- beq with zero=1, then zero=0 -> BRANCH ALU_control=110, pc_src=01; pc_en=1 only with zero=1.
- op 111111, then j with SUPPORT_JUMP=0 -> each gives illegal_op=1 in DECODE, then FETCH; no write enables asserted.
